// File: rtl/scan_host_if.sv
// Bus between the test/debug controller, scan_host and the datapath scan chain.
//   master : controller side; drives Start/Abort/Length/WrData and the chain's SDO.
//   slave  : scan_host side; drives SDI/Test to the chain and Busy/Done/RdData back.
interface scan_host_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
);
  logic             Start;
  logic             Abort;
  logic [CNT_W-1:0] Length;
  logic [WIDTH-1:0] WrData;
  logic             SDO;
  logic             SDI;
  logic             Test;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] RdData;

  modport master (
    output Start, Abort, Length, WrData, SDO,
    input  SDI, Test, Busy, Done, RdData
  );

  modport slave (
    input  Start, Abort, Length, WrData, SDO,
    output SDI, Test, Busy, Done, RdData
  );
endinterface

// File: rtl/scan_host.sv
// Master end of the datapath scan chain: serialises WrData (LSB first) into the
// chain while capturing SDO, then presents the captured bits right-justified.
// Ports:
//   Clock  : system clock, rising edge.
//   nReset : synchronous active-low reset.
//   bus    : scan_host_if.slave -- Start/Abort/Length/WrData/SDO in,
//            SDI/Test/Busy/Done/RdData out.
module scan_host #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic        Clock,
  input  logic        nReset,
  scan_host_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             test_q, test_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] len_clamp;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] cap_next;

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    shift_d  = shift_q;
    cap_d    = cap_q;
    rd_d     = rd_q;
    test_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    len_clamp = (bus.Length > WIDTH_C) ? WIDTH_C : bus.Length;
    cnt_inc   = cnt_q + CNT_W'(1);
    // SDO enters at the MSB; earlier bits drift toward bit 0.
    cap_next  = WIDTH'({bus.SDO, cap_q} >> 1);

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          len_d   = len_clamp;
          shift_d = bus.WrData;
          cap_d   = '0;
          cnt_d   = '0;
          if (len_clamp == '0) begin
            state_d = DONE;
            rd_d    = '0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        cap_d   = cap_next;
        cnt_d   = cnt_inc;
        if (bus.Abort) begin
          state_d = IDLE;
        end else if (cnt_inc == len_q) begin
          state_d = DONE;
          // First captured bit sits at WIDTH-len; move it down to bit 0.
          rd_d    = cap_next >> (WIDTH_C - len_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    test_d = (state_d == SHIFT);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      shift_q <= '0;
      cap_q   <= '0;
      rd_q    <= '0;
      test_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
      rd_q    <= rd_d;
      test_q  <= test_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.SDI    = shift_q[0];
  assign bus.Test   = test_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.RdData = rd_q;

endmodule

// File: tb/tb_scan_host.sv
// Bench for scan_host: a 16-bit chain model sits on SDI/SDO; transactions are
// table-driven plus randomized against a whole-transaction reference.
module tb_scan_host;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  scan_host_if #(.WIDTH(16), .CNT_W(5)) bus ();

  scan_host #(.WIDTH(16), .CNT_W(5)) dut (
    .Clock  (clk),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [4:0]  len;
    logic [15:0] wr;
    logic [15:0] pre;
    int          abort_at;
    bit          start_mid;
    bit          start_done;
    logic [15:0] exp_rd;
    int          exp_test;
    bit          exp_done;
    logic [15:0] exp_chain;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] ch;
  logic [15:0] last_rd;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] mask(int n);
    if (n >= 16) return 16'hFFFF;
    return 16'((32'd1 << n) - 32'd1);
  endfunction

  // Drives one transaction; the chain model ch shifts on every edge where Test is high.
  task automatic run_txn(input logic [4:0] len, input logic [15:0] wr, input int abort_at,
                         input bit start_mid, input bit start_done,
                         output int tcnt, output int dcnt, output int doff,
                         output logic [15:0] sdi_w);
    bit fin;
    tcnt = 0; dcnt = 0; doff = -1; sdi_w = '0; fin = 1'b0;
    bus.SDO    = ch[0];
    bus.Length = len;
    bus.WrData = wr;
    bus.Start  = 1'b1;
    @(negedge clk);
    bus.Start  = 1'b0;
    bus.Length = 5'($urandom);
    bus.WrData = 16'($urandom);
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      bus.Abort = 1'b0;
      bus.Start = 1'b0;
      if (bus.Done) begin
        dcnt++;
        doff = cyc;
        if (start_done) bus.Start = 1'b1;
      end
      if (bus.Test) begin
        if (tcnt < 16) sdi_w[tcnt] = bus.SDI;
        tcnt++;
        if (start_mid && tcnt == 2) bus.Start = 1'b1;
        if (abort_at == tcnt) bus.Abort = 1'b1;
        bus.SDO = ch[0];
        ch = {bus.SDI, ch[15:1]};
      end
      if (!bus.Busy) fin = 1'b1;
      else @(negedge clk);
    end
    check("txn_terminates", int'(fin), 1);
  endtask

  task automatic do_case(input vec_t v, input string tag);
    int tcnt, dcnt, doff;
    logic [15:0] sdi_w;
    ch = v.pre;
    run_txn(v.len, v.wr, v.abort_at, v.start_mid, v.start_done, tcnt, dcnt, doff, sdi_w);
    check({tag, "_test_cycles"}, tcnt, v.exp_test);
    check({tag, "_done_count"}, dcnt, v.exp_done ? 1 : 0);
    if (v.exp_done) check({tag, "_done_cycle"}, doff, v.exp_test + 1);
    check({tag, "_rddata"}, int'(bus.RdData), int'(v.exp_rd));
    check({tag, "_chain"}, int'(ch), int'(v.exp_chain));
    check({tag, "_sdi_seq"}, int'(sdi_w & mask(tcnt)), int'(v.wr & mask(v.exp_test)));
    check({tag, "_idle_after"}, int'(bus.Busy), 0);
    if (v.exp_done) last_rd = v.exp_rd;
  endtask

  // Reference: whole-transaction outcome from the clamp/abort rules.
  function automatic vec_t ref_vec(logic [4:0] len, logic [15:0] wr, logic [15:0] pre,
                                   int abort_at, bit smid, bit sdone);
    vec_t v;
    int lc, nsh;
    lc  = (int'(len) > 16) ? 16 : int'(len);
    nsh = (abort_at != 0) ? abort_at : lc;
    v.len = len; v.wr = wr; v.pre = pre; v.abort_at = abort_at;
    v.start_mid = smid; v.start_done = sdone;
    v.exp_done  = (abort_at == 0);
    v.exp_test  = nsh;
    v.exp_rd    = v.exp_done ? (pre & mask(lc)) : last_rd;
    v.exp_chain = 16'((32'(pre) >> nsh) | (32'(wr & mask(nsh)) << (16 - nsh)));
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    bus.Start = 1'b0; bus.Abort = 1'b0; bus.Length = '0; bus.WrData = '0; bus.SDO = 1'b0;
    last_rd = '0;
    //          len    wr        pre       abt mid done rd        test done chain
    vecs[0] = '{5'd16, 16'h1234, 16'hA5C3, 0, 1'b0, 1'b0, 16'hA5C3, 16, 1'b1, 16'h1234};
    vecs[1] = '{5'd4,  16'h000F, 16'h000D, 0, 1'b0, 1'b1, 16'h000D, 4,  1'b1, 16'hF000};
    vecs[2] = '{5'd20, 16'hBEEF, 16'h1357, 0, 1'b0, 1'b0, 16'h1357, 16, 1'b1, 16'hBEEF};
    vecs[3] = '{5'd0,  16'hFFFF, 16'h1111, 0, 1'b0, 1'b1, 16'h0000, 0,  1'b1, 16'h1111};
    vecs[4] = '{5'd1,  16'hFFFE, 16'h8001, 0, 1'b0, 1'b0, 16'h0001, 1,  1'b1, 16'h4000};
    vecs[5] = '{5'd16, 16'hABCD, 16'h00FF, 5, 1'b1, 1'b0, 16'h0001, 5,  1'b0, 16'h6807};

    repeat (3) @(negedge clk);
    nReset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_test",   int'(bus.Test),   0);
      check("idle_busy",   int'(bus.Busy),   0);
      check("idle_done",   int'(bus.Done),   0);
      check("idle_sdi",    int'(bus.SDI),    0);
      check("idle_rddata", int'(bus.RdData), 0);
    end

    for (int i = 0; i < 6; i++) do_case(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      logic [4:0] len;
      int lc, abt;
      len = 5'($urandom_range(0, 20));
      lc  = (int'(len) > 16) ? 16 : int'(len);
      abt = (lc != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, lc)) : 0;
      do_case(ref_vec(len, 16'($urandom), 16'($urandom), abt,
                      1'($urandom), 1'($urandom)), $sformatf("rnd%0d", i));
    end

    // Reset landing on the 8th shift edge of a 16-bit transfer.
    begin
      int tc = 0;
      ch = 16'hFFFF;
      bus.SDO = ch[0]; bus.Length = 5'd16; bus.WrData = 16'h5555; bus.Start = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      for (int c = 0; c < 40 && tc < 8; c++) begin
        if (bus.Test) begin
          tc++;
          bus.SDO = ch[0];
          ch = {bus.SDI, ch[15:1]};
          if (tc == 8) nReset = 1'b0;
        end
        if (tc < 8) @(negedge clk);
      end
      check("rst_reached_8th_shift", tc, 8);
      @(negedge clk);
      check("rst_test",   int'(bus.Test),   0);
      check("rst_busy",   int'(bus.Busy),   0);
      check("rst_done",   int'(bus.Done),   0);
      check("rst_sdi",    int'(bus.SDI),    0);
      check("rst_rddata", int'(bus.RdData), 0);
      nReset  = 1'b1;
      last_rd = '0;
      @(negedge clk);
      check("rst_done_stays_low", int'(bus.Done), 0);
      do_case(ref_vec(5'd16, 16'h9999, 16'h2468, 0, 1'b0, 1'b0), "post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_host.md
Name: scan_host

Overview:
- Master end of the datapath scan chain. Drives the chain's `SDI` and `Test` inputs and samples its `SDO` output.
- Serialises one parallel word into the chain while capturing the bits shifted out, then presents the captured word in parallel.
- Sits between the test/debug control logic and `datapath`, letting register state be loaded and unloaded without an external tester.

Parameters:
- WIDTH, 16, parallel word width and maximum bits per transaction.
- CNT_W, 5, width of `Length` and the internal bit counter; must hold WIDTH.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- nReset  input  1  synchronous active-low reset, sampled on the rising edge of Clock.
- Start  input  1  request a transaction; sampled only in IDLE.
- Abort  input  1  terminate the current shift; sampled only in SHIFT.
- Length  input  CNT_W  number of bits to shift; values above WIDTH are clamped to WIDTH.
- WrData  input  WIDTH  word to shift into the chain, LSB first.
- SDO  input  1  serial output of the datapath scan chain.
- SDI  output  1  serial input to the datapath scan chain.
- Test  output  1  scan-enable to the datapath.
- Busy  output  1  transaction in progress.
- Done  output  1  one-cycle completion pulse.
- RdData  output  WIDTH  captured chain bits, right-justified.

Behaviour:
- Reset: synchronous; nReset=0 at an edge forces the following, regardless of state (including mid-shift, where no Done is issued):
  - state=IDLE, counter=0;
  - shift and capture registers=0;
  - SDI=0, Test=0, Busy=0, Done=0, RdData=0.
- States: IDLE, SHIFT, DONE. The state is registered; Test=1 iff state==SHIFT; Busy=1 iff state is SHIFT or DONE.
- Transaction start (IDLE, Start=1 at edge k):
  - latch Lc = min(Length, WIDTH), load shift register = WrData, clear capture register;
  - if Lc!=0, go to SHIFT;
  - if Lc==0, go directly to DONE with RdData=0 and Test never asserted.
- Serial timing:
  - SDI = shift register bit 0 at all times.
  - In SHIFT, each edge shifts the shift register right by one (MSB filled with 0), shifts SDO into the capture register MSB, and increments the counter.
  - After the edge that completes the Lc-th shift, go to DONE.
- Latency: Test is high for exactly Lc cycles (k+1 .. k+Lc). Done is high in cycle k+Lc+1, then the block returns to IDLE.
- Bit ordering:
  - WrData[0] is the first bit presented on SDI.
  - The first SDO bit sampled appears at RdData[0]: RdData = capture >> (WIDTH−Lc), upper bits zero.
- RdData is updated on entry to DONE and held until the next transaction reaches DONE. Reset clears it.
- Start handling: Start while Busy=1 is ignored. Start in the Done cycle is ignored. A new transaction may start in the first IDLE cycle.
- Abort in SHIFT at an edge:
  - go to IDLE at that edge, so Test drops in the next cycle;
  - no Done pulse;
  - RdData is unchanged;
  - the shift completed at that edge still counts toward the chain (the datapath shifts on that same edge).
- Abort and the final shift at the same edge: Abort wins, no Done.
- Inputs Length and WrData are only sampled at the accepted Start edge; later changes have no effect.

Test Plan:
- Reset then idle for 5 cycles -> Test=0, Busy=0, Done=0, SDI=0, RdData=0x0000 throughout.
- Loopback (SDO tied to SDI through a 16-bit shift model preloaded 0xA5C3), Start with Length=16, WrData=0x1234 -> Test high for exactly 16 cycles, Done in cycle 17, RdData=0xA5C3, model holds 0x1234.
- SDO driven 1,0,1,1 then 0s, Length=4, WrData=0x000F -> SDI sequence 1,1,1,1; Test high 4 cycles; RdData=0x000D.
- Length=20 -> clamped to 16 shifts; Length=0 -> Done one cycle after Start, Test never high, RdData=0x0000.
- Abort asserted on 5th SHIFT edge of a 16-bit transfer -> Test high exactly 5 cycles, no Done, RdData keeps its previous value; Start pulsed during SHIFT is ignored.
- nReset=0 at the 8th SHIFT edge -> next cycle all outputs 0 and state IDLE; a subsequent full transfer completes correctly.
